// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared hazard-control state type and forwarding constants
package cpu_types_pkg;
    typedef enum logic [1:0] {RUN, LU_STALL, DWAIT, HALTED} hazard_state_t;
    localparam int FWD_RF = 0;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority forwarding select for one operand; lowest source index wins
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int REGW = 5,
    parameter int NSRC = 2,
    parameter int SELW = $clog2(NSRC + 1)
) (
    input  logic [REGW-1:0]      rs,
    input  logic [NSRC-1:0]      src_wen,
    input  logic [NSRC*REGW-1:0] src_wsel,
    output logic [SELW-1:0]      sel
);
    always_comb begin
        sel = SELW'(FWD_RF);
        for (int k = NSRC - 1; k >= 0; k--)
            if (src_wen[k] && src_wsel[k*REGW +: REGW] == rs) sel = SELW'(k + 1);
        if (rs == '0) sel = SELW'(FWD_RF);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REGW       = 5,
    parameter int NSRC       = 2,
    parameter int LU_BUBBLES = 1,
    localparam int SELW      = $clog2(NSRC + 1)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 dmemren,
    input  logic                 dmemwen,
    input  logic                 halt,
    input  logic                 branch,
    input  logic [REGW-1:0]      rs_id,
    input  logic [REGW-1:0]      rt_id,
    input  logic [REGW-1:0]      rs_ex,
    input  logic [REGW-1:0]      rt_ex,
    input  logic                 memren_ex,
    input  logic [REGW-1:0]      regwrite_ex,
    input  logic [NSRC-1:0]      src_wen,
    input  logic [NSRC*REGW-1:0] src_wsel,
    output logic [SELW-1:0]      fwd_a,
    output logic [SELW-1:0]      fwd_b,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 flush_exmem
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events
`endif
);
    localparam logic [1:0] LU_CNT = 2'(LU_BUBBLES - 1);

    hazard_state_t state, next_state;
    logic [1:0] cnt, next_cnt;
    logic dwait, lu_hazard, lu_pend;

    assign dwait     = (dmemren | dmemwen) & ~dhit;
    assign lu_hazard = memren_ex && regwrite_ex != '0 && (regwrite_ex == rs_id || regwrite_ex == rt_id);
    // cnt holds bubbles still owed after the current one; it survives a data wait
    assign lu_pend   = cnt != 2'd0;

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end

    always_comb begin
        next_cnt   = cnt;
        next_state = state;
        if (state == HALTED || dwait) begin
            next_state = (state == HALTED) ? HALTED : DWAIT;
        end else if (halt) begin
            next_state = HALTED;
            next_cnt   = '0;
        end else begin
            if (branch) next_cnt = '0;
            else if (lu_pend) next_cnt = cnt - 2'd1;
            else if (lu_hazard) next_cnt = LU_CNT;
            next_state = (next_cnt != '0) ? LU_STALL : RUN;
        end
    end

    always_comb begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        {flush_ifid, flush_idex, flush_exmem} = '0;
        if (state == HALTED || dwait) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (branch) begin
            {flush_ifid, flush_idex, flush_exmem} = '1;
        end else if (lu_pend || lu_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            flush_ifid = 1'b1;
        end
    end

    fwd_select #(.REGW(REGW), .NSRC(NSRC), .SELW(SELW)) u_fwd_a (
        .rs(rs_ex), .src_wen(src_wen), .src_wsel(src_wsel), .sel(fwd_a)
    );

    fwd_select #(.REGW(REGW), .NSRC(NSRC), .SELW(SELW)) u_fwd_b (
        .rs(rt_ex), .src_wen(src_wen), .src_wsel(src_wsel), .sel(fwd_b)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (flush_exmem && flush_events != '1) flush_events <= flush_events + 32'd1;
        end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int REGW = 5;
    localparam int NSRC = 2;
    localparam int LUB  = 2;
    localparam int SELW = $clog2(NSRC + 1);

    logic CLK = 1'b0;
    logic nRST;
    logic ihit, dhit, dmemren, dmemwen, halt, branch, memren_ex;
    logic [REGW-1:0] rs_id, rt_id, rs_ex, rt_ex, regwrite_ex;
    logic [NSRC-1:0] src_wen;
    logic [NSRC*REGW-1:0] src_wsel;
    logic [SELW-1:0] fwd_a, fwd_b;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex, flush_exmem;
    logic [7:0] ctl;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex, flush_exmem};

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REGW(REGW), .NSRC(NSRC), .LU_BUBBLES(LUB)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemren(dmemren), .dmemwen(dmemwen),
        .halt(halt), .branch(branch), .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .memren_ex(memren_ex), .regwrite_ex(regwrite_ex), .src_wen(src_wen), .src_wsel(src_wsel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    int nchk = 0;
    int npass = 0;
    bit m_halted;
    int m_bub;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit dw_now();
        return (dmemren || dmemwen) && !dhit;
    endfunction

    function automatic bit lu_now();
        return memren_ex && regwrite_ex != 0 && (regwrite_ex == rs_id || regwrite_ex == rt_id);
    endfunction

    // Control vector {pc,ifid,idex,exmem,memwb,fl_ifid,fl_idex,fl_exmem} from priority rules
    function automatic logic [7:0] exp_ctl();
        if (m_halted || dw_now()) return 8'b00000_000;
        if (branch) return 8'b11111_111;
        if (m_bub > 0 || lu_now()) return 8'b00111_010;
        if (!ihit) return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    function automatic int exp_fwd(logic [REGW-1:0] r);
        if (r == 0) return 0;
        for (int k = 0; k < NSRC; k++)
            if (src_wen[k] && src_wsel[k*REGW +: REGW] == r) return k + 1;
        return 0;
    endfunction

    task automatic idle();
        ihit = 1; dhit = 1; dmemren = 0; dmemwen = 0; halt = 0; branch = 0; memren_ex = 0;
        rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; regwrite_ex = 0; src_wen = 0; src_wsel = 0;
    endtask

    task automatic tick(string tag);
        #1;
        chk({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl()));
        chk({tag, "_fwd_a"}, 32'(fwd_a), 32'(exp_fwd(rs_ex)));
        chk({tag, "_fwd_b"}, 32'(fwd_b), 32'(exp_fwd(rt_ex)));
        if (!m_halted && !dw_now()) begin
            if (halt) begin m_halted = 1; m_bub = 0; end
            else if (branch) m_bub = 0;
            else if (m_bub > 0) m_bub--;
            else if (lu_now()) m_bub = LUB - 1;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 0;
        idle();
        #1;
        chk("rst_ctl", 32'(ctl), 32'b11111_000);
        chk("rst_fwd_a", 32'(fwd_a), 0);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", stall_cycles, 0);
        chk("rst_flush_cnt", flush_events, 0);
`endif
        m_halted = 0;
        m_bub = 0;
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        int hcnt;
        nRST = 1;
        idle();
        m_halted = 0;
        m_bub = 0;
        @(negedge CLK);
        do_reset();

        // load-use with two bubbles
        memren_ex = 1; regwrite_ex = 8; rs_id = 8;
        #1 chk("lu_bubble1", 32'(ctl), 32'b00111_010);
        tick("lu1");
        memren_ex = 0; regwrite_ex = 0;
        #1 chk("lu_bubble2", 32'(ctl), 32'b00111_010);
        tick("lu2");
        rs_id = 0;
        #1 chk("lu_done", 32'(ctl), 32'b11111_000);
        tick("lu3");

        // data wait with branch held, flushes only on dhit cycle
        dmemren = 1; dhit = 0; branch = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dw_freeze", 32'(ctl), 32'b00000_000);
            tick("dw");
        end
        dhit = 1;
        #1 chk("dw_release", 32'(ctl), 32'b11111_111);
        tick("dw_rel");
        idle();
        #1 chk("dw_after", 32'(ctl), 32'b11111_000);
        tick("dw_after");

        // forwarding priority and register 0
        src_wen = 2'b11; src_wsel = {5'd3, 5'd3}; rs_ex = 3;
        #1 chk("fwd_pri", 32'(fwd_a), 1);
        rs_ex = 0; src_wsel = '0;
        #1 chk("fwd_r0", 32'(fwd_a), 0);
        src_wen = 2'b10; src_wsel = {5'd7, 5'd0}; rt_ex = 7;
        #1 chk("fwd_src1", 32'(fwd_b), 2);
        tick("fwd");
        idle();

        // halt, then reset recovers
        halt = 1;
        #1 chk("halt_cycle", 32'(ctl), 32'b11111_000);
        tick("halt");
        halt = 0; ihit = 0; branch = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("halted", 32'(ctl), 32'b00000_000);
            tick("halted");
        end
        do_reset();
        #1 chk("post_halt", 32'(ctl), 32'b11111_000);
        tick("post_halt");

        // load-use coinciding with branch: branch wins, no stall entered
        memren_ex = 1; regwrite_ex = 5; rt_id = 5; branch = 1;
        #1 chk("lu_br", 32'(ctl), 32'b11111_111);
        tick("lu_br");
        idle();
        #1 chk("lu_br_after", 32'(ctl), 32'b11111_000);
        tick("lu_br_after");

        // reset mid load-use stall and mid data wait leaves no residue
        memren_ex = 1; regwrite_ex = 4; rs_id = 4;
        tick("lu_pre_rst");
        do_reset();
        #1 chk("rst_mid_lu", 32'(ctl), 32'b11111_000);
        tick("rst_mid_lu");
        dmemwen = 1; dhit = 0;
        tick("dw_pre_rst");
        do_reset();
        #1 chk("rst_mid_dw", 32'(ctl), 32'b11111_000);
        tick("rst_mid_dw");

`ifdef HAZARD_PERF_EN
        do_reset();
        ihit = 0;
        repeat (5) tick("perf_stall");
        ihit = 1; branch = 1;
        repeat (2) tick("perf_br");
        idle();
        #1;
        chk("perf_stall_cnt", stall_cycles, 5);
        chk("perf_flush_cnt", flush_events, 2);
        tick("perf_end");
`endif

        hcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            hcnt = m_halted ? hcnt + 1 : 0;
            if (hcnt > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                hcnt = 0;
            end
            ihit        = $urandom_range(0, 9) != 0;
            dhit        = $urandom_range(0, 3) != 0;
            dmemren     = $urandom_range(0, 2) == 0;
            dmemwen     = $urandom_range(0, 4) == 0;
            halt        = $urandom_range(0, 99) == 0;
            branch      = $urandom_range(0, 7) == 0;
            memren_ex   = $urandom_range(0, 2) == 0;
            rs_id       = REGW'($urandom_range(0, 3));
            rt_id       = REGW'($urandom_range(0, 3));
            rs_ex       = REGW'($urandom_range(0, 3));
            rt_ex       = REGW'($urandom_range(0, 3));
            regwrite_ex = REGW'($urandom_range(0, 3));
            src_wen     = NSRC'($urandom_range(0, (1 << NSRC) - 1));
            for (int k = 0; k < NSRC; k++) src_wsel[k*REGW +: REGW] = REGW'($urandom_range(0, 3));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 5, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, forwarding sources (index 0 = MEM, 1 = WB, higher = older).
REQ-003 SHALL have parameter LU_BUBBLES, default 1, bubbles inserted per load-use hazard (1..3).
REQ-004 SHALL have localparam SELW = $clog2(NSRC+1), forwarding-select width.
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 nRST  in  1  reset, asynchronous, active-low.
REQ-007 ihit, dhit  in  1 each  instruction/data memory hit.
REQ-008 dmemren, dmemwen  in  1 each  data request pending in MEM.
REQ-009 halt  in  1  halt instruction reached WB.
REQ-010 branch  in  1  taken branch/jump resolved in MEM.
REQ-011 rs_id, rt_id, rs_ex, rt_ex  in  REGW each  source registers in ID and EX.
REQ-012 memren_ex  in  1; regwrite_ex  in  REGW  load in EX and its destination.
REQ-013 src_wen  in  NSRC; src_wsel  in  NSRC*REGW  per-source write enable and destination.
REQ-014 fwd_a, fwd_b  out  SELW each  operand select: 0 = register file, k+1 = source k.
REQ-015 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage enables.
REQ-016 flush_ifid, flush_idex, flush_exmem  out  1 each  stage flushes.

Function
REQ-017 FSM states SHALL be RUN, LU_STALL, DWAIT, HALTED; outputs SHALL be combinational from state and inputs.
REQ-018 RUN with no hazard: all enables 1, all flushes 0.
REQ-019 (dmemren|dmemwen) & !dhit SHALL force all enables 0 and all flushes 0, entering/holding DWAIT; the cycle dhit rises SHALL advance all stages and return to RUN.
REQ-020 Load-use (memren_ex, regwrite_ex != 0, regwrite_ex equal to rs_id or rt_id) SHALL drive pc_en=0, ifid_en=0, flush_idex=1, and load a bubble counter with LU_BUBBLES-1; LU_STALL repeats the bubble until the counter reaches 0, then RUN.
REQ-021 Taken branch SHALL assert flush_ifid, flush_idex, flush_exmem for exactly one advancing cycle, aborting any load-use stall (counter cleared, to RUN).
REQ-022 Priority SHALL be: HALTED > data wait > branch > load-use > ihit miss.
REQ-023 Branch coinciding with data wait SHALL be held; flushes issue on the dhit cycle, not before.
REQ-024 !ihit with no higher event: pc_en=0, flush_ifid=1, later stages enabled.
REQ-025 Forwarding: lowest-index source with src_wen=1 and matching nonzero register wins; register 0 SHALL always select 0.
REQ-026 halt SHALL enter HALTED once the pipeline advances; HALTED holds all enables 0 until reset.

Reset
REQ-027 nRST low SHALL asynchronously force state RUN and bubble counter 0; with CLK idle, outputs follow REQ-018 given idle inputs.
REQ-028 Reset asserted mid-stall or mid-DWAIT SHALL abandon the stall with no residual bubbles.

Configuration
REQ-029 Macro HAZARD_PERF_EN, when defined, SHALL add outputs stall_cycles and flush_events (32 bits each, saturating, cleared by reset), counting cycles with pc_en=0 and branch-flush cycles; when undefined, neither the ports nor the counters SHALL exist.

Structure
REQ-030 hazard_state_t enum and constant FWD_RF = 0 SHALL live in cpu_types_pkg.
REQ-031 Forwarding SHALL use sub-module fwd_select (one operand, priority compare), instantiated for A and B.

Verification
REQ-032 memren_ex=1, regwrite_ex=8, rs_id=8, LU_BUBBLES=2 -> pc_en=0, flush_idex=1 for 2 cycles, then RUN.
REQ-033 dmemren=1, dhit=0 for 3 cycles, branch=1 throughout -> all enables 0 for 3 cycles; flushes only on the dhit cycle.
REQ-034 src_wen=2'b11, src_wsel={5'd3,5'd3}, rs_ex=3 -> fwd_a=1; rs_ex=0 with both writing 0 -> fwd_a=0.
REQ-035 halt=1 -> next cycle all enables 0 indefinitely; nRST pulse -> RUN.
REQ-036 Load-use plus branch in the same cycle -> flush triple asserted, no LU_STALL entry.
REQ-037 With HAZARD_PERF_EN: 5 stall cycles plus 2 branches -> stall_cycles=5, flush_events=2.
